ps2_mouse_packet_rx: RTL and testbench
======================================

Name: ps2_mouse_packet_rx

Overview:
Upstream stage of the mouse position tracker. Deserializes device-to-host PS/2 frames on PS2_DAT, clocked directly by PS2_CLK. Checks start, odd parity and stop bits, and assembles the standard 3-byte mouse packet (status, X, Y). Outputs signed 9-bit deltas, button states, a one-cycle packet strobe, and error/packet statistics; the tracker consumes these to update the binned x/y position.

Parameters:
SAT_OVF, 1, when 1 an X/Y overflow bit forces the delta to full scale (+255 / -256); when 0 the raw 9-bit value passes through.
PKT_CNT_W, 16, width of the packet counter.

Ports:
PS2_CLK  input  1  PS/2 clock, used as the block clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
PS2_DAT  input  1  PS/2 data line (input view only; tristate handling lives in the pad wrapper).
enable  input  1  when 0, bit FSM held in IDLE and byte index held at 0.
dx  output  9  signed two's-complement X delta, {xsign, xbyte}.
dy  output  9  signed two's-complement Y delta, {ysign, ybyte}.
btn_left, btn_right, btn_middle  output  1 each  status bits 0, 1, 2 of the last accepted packet.
pkt_valid  output  1  high for exactly one PS2_CLK cycle when a new packet is presented.
frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit, or a sync discard.
pkt_count  output  PKT_CNT_W  accepted packets; wraps modulo 2^PKT_CNT_W.
err_count  output  8  frame errors plus sync discards; saturates at 255.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock PS2_CLK.
- Reset:
  - All outputs 0; FSM to IDLE; byte index 0; shift register 0.
  - Reset mid-frame or mid-packet aborts everything with no pulses.
  - Reset wins over every simultaneous event.
- Bit FSM (one PS2_DAT sample per rising edge):
  - IDLE: PS2_DAT==0 -> DATA with bit_cnt=0; otherwise stay in IDLE.
  - DATA: shift LSB-first (sr <= {PS2_DAT, sr[7:1]}); after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: byte is good iff PS2_DAT==1 and XOR(sr, parity)==1 (odd parity). Always return to IDLE.
  - Bad byte: frame_err pulse, err_count+1 (saturating), byte index forced to 0, partial packet dropped.
- Packet assembler (acts on each good byte in the STOP cycle):
  - idx0: if bit3==1, store as status and go to idx1. If bit3==0, discard the byte, pulse frame_err, err_count+1, stay at idx0 (resync).
  - idx1: store X byte, go to idx2.
  - idx2: store Y byte, go to idx0, and at the same edge register the outputs below.
- Output register on packet completion:
  - dx = {status[4], xbyte}. If SAT_OVF and status[6]: dx = status[4] ? 9'h100 : 9'h0FF.
  - dy = {status[5], ybyte}. If SAT_OVF and status[7]: dy = status[5] ? 9'h100 : 9'h0FF.
  - Buttons take status[2:0].
  - pkt_valid=1 for that cycle; pkt_count+1.
- Holding and latency:
  - dx, dy and buttons hold until the next accepted packet.
  - pkt_valid and frame_err are 0 on every other edge.
  - Latency: outputs valid in the cycle after the rising edge that samples the 3rd stop bit.
- enable=0:
  - Forces IDLE and idx0 at the next edge and drops any partial frame or packet.
  - Outputs and counters hold; no pulses are generated.
- Counters: pkt_count wraps to 0 after all-ones; err_count sticks at 255.
- A frame error and a packet completion cannot occur in the same cycle (only one byte finishes per STOP).

Test Plan:
- Packet 0x29, 0x05, 0xFE, all frames good -> dx=9'h005, dy=9'h1FE (-2), btn_left=1, others 0; pkt_valid high for exactly one cycle; pkt_count=1; err_count=0.
- Byte 1 sent with bad parity, then full packet 0x08, 0x01, 0x01 -> one frame_err pulse, err_count=1, no pkt_valid for the broken packet; second packet gives dx=1, dy=1, pkt_count=1.
- Lone byte 0x00 (bit3=0) before a valid packet 0x0A, 0x00, 0x00 -> sync discard: frame_err, err_count=1; then btn_right=1, pkt_count=1.
- Packet 0x58, 0x10, 0x00 -> SAT_OVF=1: dx=9'h100, dy=0. SAT_OVF=0: dx=9'h110.
- Reset asserted after 2 good bytes, then a full packet -> outputs 0 during reset; afterwards exactly one pkt_valid, pkt_count=1.
- enable=0 while a full packet is clocked in -> no pulses, outputs and counters unchanged. Stop bit held 0 on 300 bad frames -> err_count saturates at 255.

Source files
------------

// File: rtl/ps2_mouse_packet_rx_if.sv
// Bus bundle between the PS/2 mouse receiver and its neighbours.
// The master side drives the PS/2 data line and enable and observes the
// decoded packet; the slave side is the receiver itself.
interface ps2_mouse_packet_rx_if #(
  parameter int PKT_CNT_W = 16
);
  logic                 PS2_DAT;
  logic                 enable;
  logic [8:0]           dx;
  logic [8:0]           dy;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_middle;
  logic                 pkt_valid;
  logic                 frame_err;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic [7:0]           err_count;

  modport master (
    output PS2_DAT, enable,
    input  dx, dy, btn_left, btn_right, btn_middle,
    input  pkt_valid, frame_err, pkt_count, err_count
  );

  modport slave (
    input  PS2_DAT, enable,
    output dx, dy, btn_left, btn_right, btn_middle,
    output pkt_valid, frame_err, pkt_count, err_count
  );
endinterface

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver: deserializes device-to-host frames sampled on
// the rising edge of PS2_CLK, validates start/odd-parity/stop, and assembles
// the 3-byte status/X/Y packet into signed 9-bit deltas plus button states.
module ps2_mouse_packet_rx #(
  parameter bit SAT_OVF   = 1'b1,
  parameter int PKT_CNT_W = 16
) (
  input logic                   PS2_CLK,
  input logic                   reset,
  ps2_mouse_packet_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           sr_q, sr_d;
  logic                 par_q, par_d;
  logic [1:0]           idx_q, idx_d;
  // Status byte minus the always-one sync bit: {ovf_y, ovf_x, sign_y, sign_x, mid, right, left}
  logic [6:0]           stat_q, stat_d;
  logic [7:0]           xbyte_q, xbyte_d;
  logic [8:0]           dx_q, dx_d;
  logic [8:0]           dy_q, dy_d;
  logic [2:0]           btn_q, btn_d;
  logic                 pkt_valid_q, pkt_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 byte_ok;
  logic [8:0]           dx_pkt;
  logic [8:0]           dy_pkt;
  logic [7:0]           err_count_inc;

  // Stop bit must be high and data plus parity must hold an odd number of ones.
  assign byte_ok       = bus.PS2_DAT & (^{sr_q, par_q});
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  // Bit FSM state register.
  always_ff @(posedge PS2_CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Bit FSM next-state: one PS2_DAT sample per edge, forced idle while disabled.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!bus.PS2_DAT) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Deltas for a packet completing now; the Y byte is the one in the shifter.
  always_comb begin
    dx_pkt = {stat_q[3], xbyte_q};
    dy_pkt = {stat_q[4], sr_q};
    if (SAT_OVF && stat_q[5]) dx_pkt = stat_q[3] ? 9'h100 : 9'h0FF;
    if (SAT_OVF && stat_q[6]) dy_pkt = stat_q[4] ? 9'h100 : 9'h0FF;
  end

  // FSM outputs: shifter, packet assembler, output register loads and counters.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    idx_d       = idx_q;
    stat_d      = stat_q;
    xbyte_d     = xbyte_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    btn_d       = btn_q;
    pkt_valid_d = 1'b0;
    frame_err_d = 1'b0;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    if (!bus.enable) begin
      idx_d     = 2'd0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          sr_d      = {bus.PS2_DAT, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          par_d = bus.PS2_DAT;
        end
        STOP: begin
          if (!byte_ok) begin
            // Broken frame: drop any partial packet and resync on a status byte.
            frame_err_d = 1'b1;
            err_count_d = err_count_inc;
            idx_d       = 2'd0;
          end else begin
            case (idx_q)
              2'd0: begin
                if (sr_q[3]) begin
                  stat_d = {sr_q[7:4], sr_q[2:0]};
                  idx_d  = 2'd1;
                end else begin
                  // Not a status byte: we are out of step with the device.
                  frame_err_d = 1'b1;
                  err_count_d = err_count_inc;
                end
              end
              2'd1: begin
                xbyte_d = sr_q;
                idx_d   = 2'd2;
              end
              default: begin
                dx_d        = dx_pkt;
                dy_d        = dy_pkt;
                btn_d       = stat_q[2:0];
                pkt_valid_d = 1'b1;
                pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
                idx_d       = 2'd0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      sr_q        <= 8'd0;
      par_q       <= 1'b0;
      idx_q       <= 2'd0;
      stat_q      <= 7'd0;
      xbyte_q     <= 8'd0;
      dx_q        <= 9'd0;
      dy_q        <= 9'd0;
      btn_q       <= 3'd0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= 8'd0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      stat_q      <= stat_d;
      xbyte_q     <= xbyte_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      btn_q       <= btn_d;
      pkt_valid_q <= pkt_valid_d;
      frame_err_q <= frame_err_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.dx         = dx_q;
  assign bus.dy         = dy_q;
  assign bus.btn_left   = btn_q[0];
  assign bus.btn_right  = btn_q[1];
  assign bus.btn_middle = btn_q[2];
  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.pkt_count  = pkt_count_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: two instances (saturating and raw overflow
// handling) share one PS/2 line. Stimulus pushes expected packets / errors
// into queues; a monitor pops and compares whenever a pulse appears.
module tb_ps2_mouse_packet_rx;

  logic clk = 1'b0;
  logic reset;
  logic dat;
  logic en;

  always #5 clk = ~clk;

  ps2_mouse_packet_rx_if #(.PKT_CNT_W(16)) bus_s ();
  ps2_mouse_packet_rx_if #(.PKT_CNT_W(16)) bus_r ();

  assign bus_s.PS2_DAT = dat;
  assign bus_s.enable  = en;
  assign bus_r.PS2_DAT = dat;
  assign bus_r.enable  = en;

  ps2_mouse_packet_rx #(.SAT_OVF(1'b1), .PKT_CNT_W(16)) dut_s (
    .PS2_CLK (clk),
    .reset   (reset),
    .bus     (bus_s)
  );

  ps2_mouse_packet_rx #(.SAT_OVF(1'b0), .PKT_CNT_W(16)) dut_r (
    .PS2_CLK (clk),
    .reset   (reset),
    .bus     (bus_r)
  );

  typedef struct {
    logic [8:0]  dx_s;
    logic [8:0]  dy_s;
    logic [8:0]  dx_r;
    logic [8:0]  dy_r;
    logic [2:0]  btn;
    logic [15:0] pc;
    logic [7:0]  ec;
  } pkt_t;

  pkt_t       pkt_q[$];
  logic [7:0] err_q[$];
  pkt_t       last_pkt;
  pkt_t       mon_p;
  logic [7:0] mon_e;
  int         tests = 0;
  int         fails = 0;
  int         exp_pc = 0;
  int         exp_ec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    @(negedge clk);
    dat = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out((~^b) ^ bad_par);
    bit_out(~bad_stop);
    bit_out(1'b1);
  endtask

  task automatic expect_err();
    exp_ec = (exp_ec >= 255) ? 255 : exp_ec + 1;
    err_q.push_back(exp_ec[7:0]);
  endtask

  task automatic expect_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    pkt_t p;
    p.dx_r = {s[4], x};
    p.dy_r = {s[5], y};
    p.dx_s = s[6] ? (s[4] ? 9'h100 : 9'h0FF) : p.dx_r;
    p.dy_s = s[7] ? (s[5] ? 9'h100 : 9'h0FF) : p.dy_r;
    p.btn  = s[2:0];
    exp_pc = exp_pc + 1;
    p.pc   = exp_pc[15:0];
    p.ec   = exp_ec[7:0];
    pkt_q.push_back(p);
    last_pkt = p;
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    expect_pkt(s, x, y);
    send_byte(s, 1'b0, 1'b0);
    send_byte(x, 1'b0, 1'b0);
    send_byte(y, 1'b0, 1'b0);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, " dx_s"}, {23'd0, bus_s.dx}, {23'd0, last_pkt.dx_s});
    chk({tag, " dy_s"}, {23'd0, bus_s.dy}, {23'd0, last_pkt.dy_s});
    chk({tag, " btn"}, {29'd0, bus_s.btn_middle, bus_s.btn_right, bus_s.btn_left},
        {29'd0, last_pkt.btn});
    chk({tag, " pkt_count"}, {16'd0, bus_s.pkt_count}, exp_pc);
    chk({tag, " err_count"}, {24'd0, bus_s.err_count}, exp_ec);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus_s.pkt_valid || bus_r.pkt_valid) begin
      if (pkt_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL pkt_valid: got unexpected pulse (s=%0b r=%0b), expected none",
                 bus_s.pkt_valid, bus_r.pkt_valid);
      end else begin
        mon_p = pkt_q.pop_front();
        chk("pkt_valid_r", {31'd0, bus_r.pkt_valid}, 32'd1);
        chk("dx_sat", {23'd0, bus_s.dx}, {23'd0, mon_p.dx_s});
        chk("dy_sat", {23'd0, bus_s.dy}, {23'd0, mon_p.dy_s});
        chk("dx_raw", {23'd0, bus_r.dx}, {23'd0, mon_p.dx_r});
        chk("dy_raw", {23'd0, bus_r.dy}, {23'd0, mon_p.dy_r});
        chk("buttons", {29'd0, bus_s.btn_middle, bus_s.btn_right, bus_s.btn_left},
            {29'd0, mon_p.btn});
        chk("pkt_count", {16'd0, bus_s.pkt_count}, {16'd0, mon_p.pc});
        chk("err_count@pkt", {24'd0, bus_s.err_count}, {24'd0, mon_p.ec});
      end
    end
    if (bus_s.frame_err || bus_r.frame_err) begin
      if (err_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL frame_err: got unexpected pulse (s=%0b r=%0b), expected none",
                 bus_s.frame_err, bus_r.frame_err);
      end else begin
        mon_e = err_q.pop_front();
        chk("frame_err_r", {31'd0, bus_r.frame_err}, 32'd1);
        chk("err_count", {24'd0, bus_s.err_count}, {24'd0, mon_e});
      end
    end
  end

  initial begin
    reset = 1'b1;
    dat   = 1'b1;
    en    = 1'b1;
    last_pkt = '{default: '0};
    repeat (3) @(negedge clk);
    chk_hold("reset");
    chk("reset pkt_valid", {31'd0, bus_s.pkt_valid}, 32'd0);
    chk("reset frame_err", {31'd0, bus_s.frame_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic packet: left button, dx=+5, dy=-2.
    send_pkt(8'h29, 8'h05, 8'hFE);
    $display("[TB] packet 29/05/FE sent");
    chk_hold("pkt1");

    // Bad parity on a status byte, then on an X byte, then a clean packet.
    expect_err();
    send_byte(8'h08, 1'b1, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    expect_err();
    send_byte(8'h01, 1'b1, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h01);
    $display("[TB] parity errors then packet 08/01/01 sent");
    chk_hold("parity");

    // Sync discard: a byte without bit3 while waiting for status.
    expect_err();
    send_byte(8'h00, 1'b0, 1'b0);
    send_pkt(8'h0A, 8'h00, 8'h00);
    $display("[TB] sync discard then packet 0A/00/00 sent");

    // Overflow handling: negative X overflow, then positive Y overflow.
    send_pkt(8'h58, 8'h10, 8'h00);
    send_pkt(8'h88, 8'h00, 8'h05);
    $display("[TB] overflow packets 58/10/00 and 88/00/05 sent");

    // Reset after two good bytes of a packet.
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 0;
    exp_ec = 0;
    last_pkt = '{default: '0};
    repeat (2) @(negedge clk);
    chk_hold("in-reset");
    reset = 1'b0;
    @(negedge clk);
    send_pkt(8'h09, 8'h03, 8'h04);
    $display("[TB] reset mid-packet then packet 09/03/04 sent");
    chk_hold("post-reset");

    // Whole packet while disabled: nothing may change.
    en = 1'b0;
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    chk_hold("disabled");
    $display("[TB] disabled packet 0A/33/44 ignored");

    // Disable mid-packet must restart byte indexing at status.
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    send_pkt(8'h0C, 8'h02, 8'h03);
    $display("[TB] disable mid-packet then packet 0C/02/03 sent");

    // Error counter saturation via bad stop bits.
    for (int i = 0; i < 300; i++) begin
      expect_err();
      send_byte(8'hA5, 1'b0, 1'b1);
    end
    $display("[TB] 300 bad-stop frames sent");
    chk_hold("saturated");
    chk("err_count saturated", {24'd0, bus_s.err_count}, 32'd255);

    repeat (5) @(negedge clk);
    chk("pkt queue drained", pkt_q.size(), 32'd0);
    chk("err queue drained", err_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
